// File: rtl/flag_status_unit_pkg.sv
// Shared definitions for the flags producer: ALU operation classes and the
// bit positions of V/C/Z/N inside the 4-bit flags word.
package flag_status_unit_pkg;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'd0,
    ALU_SUB  = 3'd1,
    ALU_AND  = 3'd2,
    ALU_OR   = 3'd3,
    ALU_XOR  = 3'd4,
    ALU_SHL  = 3'd5,
    ALU_SHR  = 3'd6,
    ALU_PASS = 3'd7
  } alu_op_e;

  // Same indices are used by the ALU and the branch decision logic.
  localparam int FLAG_V  = 0;
  localparam int FLAG_C  = 1;
  localparam int FLAG_Z  = 2;
  localparam int FLAG_N  = 3;
  localparam int FLAGS_W = 4;

  typedef logic [FLAGS_W-1:0] flags_t;

endpackage

// File: rtl/flag_status_unit_compute.sv
// Combinational V/C/Z/N derivation for one completed ALU operation.
// Only the operand bits the flag rules actually look at are brought in,
// which keeps the port list honest about what the flags depend on.
module flag_compute
  import flag_status_unit_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  alu_op_e          op_i,
  input  logic             a_msb_i,
  input  logic             a_lsb_i,
  input  logic             b_msb_i,
  input  logic [WIDTH-1:0] result_i,
  input  logic             carry_i,
  input  flags_t           old_flags_i,
  output flags_t           new_flags_o
);

  logic r_msb;
  assign r_msb = result_i[WIDTH-1];

  // Z/N come from the result for every op; C/V depend on the op class.
  always_comb begin
    new_flags_o         = old_flags_i;
    new_flags_o[FLAG_Z] = (result_i == '0);
    new_flags_o[FLAG_N] = r_msb;
    case (op_i)
      ALU_ADD: begin
        new_flags_o[FLAG_C] = carry_i;
        new_flags_o[FLAG_V] = (a_msb_i == b_msb_i) & (r_msb != a_msb_i);
      end
      ALU_SUB: begin
        new_flags_o[FLAG_C] = carry_i;
        new_flags_o[FLAG_V] = (a_msb_i != b_msb_i) & (r_msb != a_msb_i);
      end
      ALU_AND, ALU_OR, ALU_XOR: begin
        new_flags_o[FLAG_C] = 1'b0;
        new_flags_o[FLAG_V] = 1'b0;
      end
      ALU_SHL: begin
        new_flags_o[FLAG_C] = a_msb_i;
        new_flags_o[FLAG_V] = r_msb ^ a_msb_i;
      end
      ALU_SHR: begin
        new_flags_o[FLAG_C] = a_lsb_i;
        new_flags_o[FLAG_V] = 1'b0;
      end
      default: ; // PASS keeps C/V
    endcase
  end

endmodule

// File: rtl/flag_status_unit.sv
// Architectural flags register with explicit restore and a LIFO shadow
// stack for save/restore across calls and interrupts.
module flag_status_unit
  import flag_status_unit_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int STACK_DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             alu_valid_i,
  input  logic [2:0]       alu_op_i,
  input  logic [WIDTH-1:0] op_a_i,
  input  logic [WIDTH-1:0] op_b_i,
  input  logic [WIDTH-1:0] result_i,
  input  logic             carry_out_i,
  input  logic             set_valid_i,
  input  logic [3:0]       set_value_i,
  input  logic             push_i,
  input  logic             pop_i,
  output logic [3:0]       flags_o,
  output logic             stack_empty_o,
  output logic             stack_full_o,
  output logic             stack_err_o
);

  localparam int IDX_W = $clog2(STACK_DEPTH);
  localparam int PTR_W = IDX_W + 1;  // sp spans 0..STACK_DEPTH inclusive

  flags_t             flags_q, flags_d;
  flags_t             alu_flags;
  flags_t             stack_q [STACK_DEPTH];
  logic [PTR_W-1:0]   sp_q, sp_d;
  logic               empty_q, full_q, err_q;
  logic [IDX_W-1:0]   wr_idx, rd_idx;
  logic               push_ok, pop_ok, err_set;

  flag_compute #(.WIDTH(WIDTH)) u_compute (
    .op_i        (alu_op_e'(alu_op_i)),
    .a_msb_i     (op_a_i[WIDTH-1]),
    .a_lsb_i     (op_a_i[0]),
    .b_msb_i     (op_b_i[WIDTH-1]),
    .result_i    (result_i),
    .carry_i     (carry_out_i),
    .old_flags_i (flags_q),
    .new_flags_o (alu_flags)
  );

  // A push+pop collision cancels both; overflow/underflow are simply dropped.
  assign push_ok = push_i & ~pop_i & ~full_q;
  assign pop_ok  = pop_i & ~push_i & ~empty_q;
  assign err_set = (push_i & pop_i) | (push_i & full_q) | (pop_i & empty_q);

  // When sp == STACK_DEPTH the low bits wrap to 0, so wr_idx-1 still names the top entry.
  assign wr_idx = sp_q[IDX_W-1:0];
  assign rd_idx = wr_idx - IDX_W'(1);

  // Next flags by priority pop > set > alu, and next stack pointer.
  always_comb begin
    flags_d = flags_q;
    sp_d    = sp_q;
    if (pop_ok) begin
      flags_d = stack_q[rd_idx];
      sp_d    = sp_q - PTR_W'(1);
    end else if (set_valid_i) begin
      flags_d = set_value_i;
    end else if (alu_valid_i) begin
      flags_d = alu_flags;
    end
    if (push_ok) begin
      sp_d = sp_q + PTR_W'(1);
    end
  end

  // State update; reset also wipes the stack contents.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      flags_q <= '0;
      sp_q    <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      err_q   <= 1'b0;
      for (int i = 0; i < STACK_DEPTH; i++) begin
        stack_q[i] <= '0;
      end
    end else begin
      flags_q <= flags_d;
      sp_q    <= sp_d;
      empty_q <= (sp_d == '0);
      full_q  <= (sp_d == PTR_W'(STACK_DEPTH));
      err_q   <= err_q | err_set;
      if (push_ok) begin
        stack_q[wr_idx] <= flags_q;  // snapshot is the pre-edge value
      end
    end
  end

  assign flags_o       = flags_q;
  assign stack_empty_o = empty_q;
  assign stack_full_o  = full_q;
  assign stack_err_o   = err_q;

endmodule

// File: tb/tb_flag_status_unit.sv
// Directed bench for flag_status_unit with a behavioural reference model
// checked every cycle, plus literal expectations at key points.
module tb_flag_status_unit;
  import flag_status_unit_pkg::*;

  localparam int W = 16;
  localparam int D = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          alu_valid = 1'b0, carry_out = 1'b0, set_valid = 1'b0;
  logic          push = 1'b0, pop = 1'b0;
  logic [2:0]    alu_op = 3'd0;
  logic [W-1:0]  op_a = '0, op_b = '0, result = '0;
  logic [3:0]    set_value = '0;
  logic [3:0]    flags;
  logic          stack_empty, stack_full, stack_err;

  int checks = 0;
  int failures = 0;

  flag_status_unit #(.WIDTH(W), .STACK_DEPTH(D)) dut (
    .clk_i(clk), .rst_i(rst), .alu_valid_i(alu_valid), .alu_op_i(alu_op),
    .op_a_i(op_a), .op_b_i(op_b), .result_i(result), .carry_out_i(carry_out),
    .set_valid_i(set_valid), .set_value_i(set_value), .push_i(push), .pop_i(pop),
    .flags_o(flags), .stack_empty_o(stack_empty), .stack_full_o(stack_full),
    .stack_err_o(stack_err)
  );

  // Reference model state
  logic [3:0] m_flags = 4'b0000;
  logic [3:0] m_stack[$];
  logic       m_err = 1'b0;

  function automatic int to_signed(input logic [W-1:0] x);
    return (x >= 16'h8000) ? int'(x) - 65536 : int'(x);
  endfunction

  function automatic bit out_of_range(input int t);
    return (t > 32767) || (t < -32768);
  endfunction

  // Flags from arithmetic meaning: overflow = signed result out of range.
  function automatic logic [3:0] exp_alu(input logic [2:0] op, input logic [W-1:0] a, b, r,
                                         input logic cout, input logic [3:0] old);
    logic v, c;
    v = old[0];
    c = old[1];
    case (op)
      ALU_ADD: begin c = cout; v = out_of_range(to_signed(a) + to_signed(b)); end
      ALU_SUB: begin c = cout; v = out_of_range(to_signed(a) - to_signed(b)); end
      ALU_AND, ALU_OR, ALU_XOR: begin c = 1'b0; v = 1'b0; end
      ALU_SHL: begin c = (a >= 16'h8000); v = out_of_range(to_signed(a) * 2); end
      ALU_SHR: begin c = (a % 2 == 1); v = 1'b0; end
      default: ;
    endcase
    return {(r >= 16'h8000), (r == 0), c, v};
  endfunction

  task automatic chk(input string name, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got=%b expected=%b", name, $time, got, exp);
    end
  endtask

  // Compare process: advance the model on each edge, then check the DUT.
  always @(posedge clk) begin
    logic [3:0] nf;
    bit popped;
    popped = 0;
    nf = m_flags;
    if (rst) begin
      m_flags = 4'b0000;
      m_stack.delete();
      m_err = 1'b0;
    end else begin
      if (push && pop) m_err = 1'b1;
      else if (push) begin
        if (m_stack.size() == D) m_err = 1'b1;
        else m_stack.push_back(m_flags);
      end else if (pop) begin
        if (m_stack.size() == 0) m_err = 1'b1;
        else begin nf = m_stack.pop_back(); popped = 1; end
      end
      if (!popped) begin
        if (set_valid) nf = set_value;
        else if (alu_valid) nf = exp_alu(alu_op, op_a, op_b, result, carry_out, m_flags);
      end
      m_flags = nf;
    end
    #1;
    chk("model_flags", flags, m_flags);
    chk("model_empty", {3'b0, stack_empty}, {3'b0, m_stack.size() == 0});
    chk("model_full",  {3'b0, stack_full},  {3'b0, m_stack.size() == D});
    chk("model_err",   {3'b0, stack_err},   {3'b0, m_err});
  end

  // Present a consistent ALU writeback for op/a/b.
  task automatic drive_alu(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int s;
    alu_valid = 1'b1;
    alu_op = op;
    op_a = a;
    op_b = b;
    carry_out = 1'b0;
    case (op)
      ALU_ADD: begin s = int'(a) + int'(b); result = W'(s); carry_out = (s > 65535); end
      ALU_SUB: begin result = a - b; carry_out = (a < b); end
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_XOR: result = a ^ b;
      ALU_SHL: result = a << 1;
      ALU_SHR: result = a >> 1;
      default: result = b;
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
    rst = 1'b0;
    alu_valid = 1'b0;
    set_valid = 1'b0;
    push = 1'b0;
    pop = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  logic [3:0] vals [4];

  initial begin
    vals[0] = 4'h3; vals[1] = 4'h5; vals[2] = 4'h9; vals[3] = 4'hC;

    tick();
    chk("rst_flags", flags, 4'b0000);
    chk("rst_empty", {3'b0, stack_empty}, 4'd1);
    chk("rst_full",  {3'b0, stack_full},  4'd0);
    chk("rst_err",   {3'b0, stack_err},   4'd0);

    drive_alu(ALU_ADD, 16'h7FFF, 16'h0001); tick();
    chk("add_ovf", flags, 4'b1001);
    drive_alu(ALU_SUB, 16'h0005, 16'h0005); tick();
    chk("sub_zero", flags, 4'b0100);
    drive_alu(ALU_PASS, 16'h0000, 16'hFFFF); tick();
    chk("pass_hold", flags, 4'b1000);
    drive_alu(ALU_SHL, 16'hC000, 16'h0000); tick();
    chk("shl_carry", flags, 4'b1010);
    drive_alu(ALU_SHL, 16'h4000, 16'h0000); tick();
    chk("shl_ovf", flags, 4'b1001);
    drive_alu(ALU_SHR, 16'h0001, 16'h0000); tick();
    chk("shr_carry", flags, 4'b0110);
    drive_alu(ALU_SUB, 16'h8000, 16'h0001); tick();
    chk("sub_ovf", flags, 4'b0001);
    drive_alu(ALU_SUB, 16'h0001, 16'h0002); tick();
    chk("sub_borrow", flags, 4'b1010);
    drive_alu(ALU_AND, 16'hF0F0, 16'h0F0F); tick();
    chk("and_zero", flags, 4'b0100);
    drive_alu(ALU_XOR, 16'hF0F0, 16'h0F0F); tick();
    chk("xor_neg", flags, 4'b1000);

    set_valid = 1'b1; set_value = 4'b1010; drive_alu(ALU_ADD, 16'h0000, 16'h0000); tick();
    chk("set_over_alu", flags, 4'b1010);

    set_valid = 1'b1; set_value = 4'b0010; tick();
    push = 1'b1; drive_alu(ALU_ADD, 16'h0000, 16'h0000); tick();
    chk("push_alu_flags", flags, 4'b0100);
    pop = 1'b1; tick();
    chk("pop_restore", flags, 4'b0010);
    chk("pop_empty", {3'b0, stack_empty}, 4'd1);
    chk("no_err_yet", {3'b0, stack_err}, 4'd0);

    for (int i = 0; i < D; i++) begin
      set_valid = 1'b1; set_value = vals[i]; tick();
      push = 1'b1; tick();
    end
    chk("fill_full", {3'b0, stack_full}, 4'd1);
    push = 1'b1; tick();
    chk("ovf_err", {3'b0, stack_err}, 4'd1);
    chk("ovf_still_full", {3'b0, stack_full}, 4'd1);
    for (int i = 0; i < D; i++) begin
      pop = 1'b1; tick();
      chk("lifo_order", flags, vals[D-1-i]);
    end
    chk("drained_empty", {3'b0, stack_empty}, 4'd1);

    pop = 1'b1; set_valid = 1'b1; set_value = 4'b1111; tick();
    chk("underflow_set", flags, 4'b1111);
    push = 1'b1; tick();
    set_valid = 1'b1; set_value = 4'b0011; tick();
    pop = 1'b1; set_valid = 1'b1; set_value = 4'b0101; tick();
    chk("pop_beats_set", flags, 4'b1111);

    for (int i = 0; i < 3; i++) begin
      push = 1'b1; tick();
    end
    rst = 1'b1; push = 1'b1; set_valid = 1'b1; set_value = 4'b1110; tick();
    chk("midrst_flags", flags, 4'b0000);
    chk("midrst_empty", {3'b0, stack_empty}, 4'd1);
    chk("midrst_err",   {3'b0, stack_err},   4'd0);

    set_valid = 1'b1; set_value = 4'b0110; tick();
    push = 1'b1; tick();
    push = 1'b1; pop = 1'b1; set_valid = 1'b1; set_value = 4'b0111; tick();
    chk("collide_flags", flags, 4'b0111);
    chk("collide_err", {3'b0, stack_err}, 4'd1);
    pop = 1'b1; tick();
    chk("collide_kept", flags, 4'b0110);

    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 1) == 1)
        drive_alu(3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom));
      set_valid = ($urandom_range(0, 4) == 0);
      set_value = 4'($urandom);
      push = ($urandom_range(0, 3) == 0);
      pop = ($urandom_range(0, 3) == 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
